// File: rtl/mem_access_unit.sv
// Memory-stage controller: turns an EX/Mem load/store into a req/ack
// transaction on a variable-latency data-memory port, stalls the pipeline
// until it completes, and reports misaligned accesses and bus timeouts.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  logic [31:0]           alu_result_in,
  input  logic [31:0]           write_data_in,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic [31:0]           mem_read_data_out,
  output logic                  stall_out,
  output logic                  misalign_err,
  output logic                  bus_err
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] wait_cnt;

  logic access;
  logic misaligned;
  logic timeout;

  // Both enables high is treated as a store: dmem_we simply follows mem_write_en.
  assign access     = mem_read_en | mem_write_en;
  assign misaligned = (alu_result_in[1:0] != 2'b00);
  assign timeout    = (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and stall decode; stall depends on the live request in IDLE.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    stall_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (access && !misaligned) begin
          stall_out  = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        stall_out = 1'b1;
        if (dmem_ack || timeout) next_state = DONE;
      end
      DONE: begin
        // One free cycle lets Mem_WB capture; the held request is not re-evaluated.
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Memory port, result register, wait counter and error pulses.
  // NOTE: every register here is reset explicitly; this block holds plain
  // flops, not a memory array, so reset costs nothing and keeps outputs defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      mem_read_data_out <= '0;
      misalign_err      <= 1'b0;
      bus_err           <= 1'b0;
      wait_cnt          <= '0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              misalign_err      <= 1'b1;
              mem_read_data_out <= '0;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write_en;
              dmem_addr  <= alu_result_in[ADDR_WIDTH-1:0];
              dmem_wdata <= write_data_in;
              wait_cnt   <= '0;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            // An ack on the timeout cycle still completes normally.
            dmem_req <= 1'b0;
            if (!dmem_we) mem_read_data_out <= dmem_rdata;
          end else if (timeout) begin
            dmem_req          <= 1'b0;
            bus_err           <= 1'b1;
            mem_read_data_out <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage controller between the EX/Mem pipeline register and Mem_WB.
- Converts the load/store request carried by the EX/Mem register into a req/ack transaction on a variable-latency data-memory port.
- Stalls the upstream pipeline until the transaction completes, then presents the load word on mem_read_data_out for Mem_WB to capture.
- Flags misaligned accesses and bus timeouts.

Parameters:
- ADDR_WIDTH, 32, width of the data-memory address bus.
- TIMEOUT_CYCLES, 16, maximum cycles dmem_req stays high without dmem_ack before a bus error is declared (must be ≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- mem_read_en  in  1  load request from EX/Mem.
- mem_write_en  in  1  store request from EX/Mem.
- alu_result_in  in  32  byte address from EX/Mem; low ADDR_WIDTH bits used.
- write_data_in  in  32  store data from EX/Mem.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = write, 0 = read, registered.
- dmem_addr  out  ADDR_WIDTH  word-aligned address, registered.
- dmem_wdata  out  32  store data, registered.
- dmem_rdata  in  32  read data, valid only when dmem_ack=1.
- dmem_ack  in  1  single-cycle completion strobe.
- mem_read_data_out  out  32  load result for Mem_WB.
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/Mem; combinational from state and inputs.
- misalign_err  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on a timeout.

Behaviour:
- Reset (rst=0, immediate, asynchronous):
  - State goes to IDLE.
  - dmem_req, dmem_we, misalign_err and bus_err go to 0.
  - dmem_addr, dmem_wdata and mem_read_data_out go to 0.
  - Timeout counter clears.
  - Reset mid-transaction drops dmem_req at once. A later dmem_ack is ignored.
- Request decode:
  - access = mem_read_en | mem_write_en.
  - If both are high, the access is treated as a write.
- IDLE:
  - access=0: stall_out=0 and the state stays IDLE.
  - access=1 with alu_result_in[1:0]≠0:
    - No memory request is issued and stall_out=0.
    - misalign_err=1 on the next cycle.
    - mem_read_data_out is forced to 0 on the next edge.
    - The state stays IDLE.
  - access=1 and aligned:
    - stall_out=1.
    - On the edge: dmem_req←1, dmem_we←mem_write_en, dmem_addr←alu_result_in, dmem_wdata←write_data_in, counter←0.
    - Next state ACCESS.
- ACCESS:
  - stall_out=1, and dmem_req, dmem_addr, dmem_wdata and dmem_we stay stable.
  - dmem_ack=1:
    - mem_read_data_out←dmem_rdata if it is a read, unchanged if it is a write.
    - dmem_req←0 and next state DONE.
  - dmem_ack=0 and counter==TIMEOUT_CYCLES-1:
    - dmem_req←0, bus_err←1 for one cycle, mem_read_data_out←0.
    - Next state DONE.
  - Otherwise the counter increments.
  - If ack and timeout fall in the same cycle, ack wins and there is no bus_err.
- DONE:
  - stall_out=0 for exactly one cycle, so the pipeline advances and Mem_WB captures mem_read_data_out.
  - Next state IDLE unconditionally.
  - The request present in this cycle is not evaluated, which prevents the just-served instruction from being reissued.
- Latency:
  - An ack in the first ACCESS cycle gives 2 stall cycles (IDLE and ACCESS) and completion on the 3rd cycle.
  - Each extra wait cycle adds one stall cycle.
- mem_read_data_out holds its value in IDLE.
- dmem_ack seen in IDLE or DONE is ignored.
- dmem_rdata is sampled only on an ack during a read.
- Counter width is clog2(TIMEOUT_CYCLES)+1. The counter never wraps.

Test Plan:
- Reset: hold rst=0 with ack toggling → all outputs 0, state IDLE; release → first cycle with no access gives stall_out=0.
- Load, zero-wait: mem_read_en=1, addr=0x40; memory acks on the first req cycle with rdata=0xDEADBEEF → stall_out=1 for 2 cycles, dmem_addr=0x40 and dmem_we=0, then DONE with mem_read_data_out=0xDEADBEEF and stall_out=0.
- Store, 3-wait: mem_write_en=1, addr=0x100, data=0x12345678; ack after 3 cycles → dmem_we=1, dmem_wdata stable throughout, stall_out=1 for 5 cycles, mem_read_data_out unchanged.
- Misaligned: mem_read_en=1, addr=0x43 → dmem_req stays 0, stall_out=0, misalign_err pulses once, mem_read_data_out=0.
- Timeout with TIMEOUT_CYCLES=4 and no ack → dmem_req high exactly 4 cycles, bus_err pulses once, mem_read_data_out=0, then DONE → IDLE; ack and timeout in the same cycle → no bus_err and data captured.
- Reset mid-access: rst=0 in the 2nd ACCESS cycle → dmem_req drops in that cycle with no clock edge; ack after release is ignored and stall_out=0.
